div_seq_unit: RTL and testbench

- Parametrised successor to the EX-stage divide decoder.
- Decodes DIV/DIVU in EX and runs a WIDTH-cycle restoring radix-2 divider.
- Drives the pipeline stall and returns HI (remainder) / LO (quotient) with a one-shot HI/LO write strobe.
- Adds flush cancellation, external-stall hold, divide-by-zero handling and back-to-back issue.

---
 rtl/div_seq_unit.sv | 107 ++++++++++
 tb/tb_div_seq_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_unit.sv
// EX-stage DIV/DIVU decoder driving a WIDTH-cycle restoring radix-2 divider.
// Results land on hi_o (remainder) / lo_o (quotient) with a one-shot hilo_we commit.
module div_seq_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter logic [5:0]  RTYPE_OP   = 6'b000000,
   parameter logic [5:0]  DIV_FUNCT  = 6'b011010,
   parameter logic [5:0]  DIVU_FUNCT = 6'b011011
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   input  logic             ext_stall,
   output logic             stall_div,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quot, dvsr;
   logic             signed_mode, rs_neg, rt_neg, zero_div;

   logic             is_div, start, is_signed, last_step;
   logic [WIDTH-1:0] rs_mag, rt_mag;
   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] rem_nxt, quot_nxt, q_res, r_pre, r_res;

   always_comb begin
      is_div    = (op == RTYPE_OP) && (funct == DIV_FUNCT || funct == DIVU_FUNCT);
      is_signed = (funct == DIV_FUNCT);
      start     = (state == IDLE) && is_div && !flush;
      rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
      rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

      shifted  = {rem, quot[WIDTH-1]};
      diff     = shifted - {1'b0, dvsr};
      rem_nxt  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], ~diff[WIDTH]};

      last_step = zero_div || (count == CW'(1));
      q_res = zero_div ? '1
            : ((signed_mode && (rs_neg ^ rt_neg)) ? -quot_nxt : quot_nxt);
      // On a zero divisor quot still holds the dividend magnitude; re-signing it
      // recovers the original rs_val, including the most-negative value.
      r_pre = zero_div ? quot : rem_nxt;
      r_res = (signed_mode && rs_neg) ? -r_pre : r_pre;

      stall_div = start || ((state == BUSY) && !flush);
      hilo_we   = (state == DONE) && !ext_stall && !flush;
      div_zero  = hilo_we && zero_div;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         rem         <= '0;
         quot        <= '0;
         dvsr        <= '0;
         signed_mode <= 1'b0;
         rs_neg      <= 1'b0;
         rt_neg      <= 1'b0;
         zero_div    <= 1'b0;
         hi_o        <= '0;
         lo_o        <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (is_div) begin
               signed_mode <= is_signed;
               rs_neg      <= is_signed && rs_val[WIDTH-1];
               rt_neg      <= is_signed && rt_val[WIDTH-1];
               zero_div    <= (rt_val == '0);
               quot        <= rs_mag;
               dvsr        <= rt_mag;
               rem         <= '0;
               count       <= CW'(WIDTH);
               state       <= BUSY;
            end
            BUSY: begin
               rem   <= rem_nxt;
               quot  <= quot_nxt;
               count <= count - 1'b1;
               if (last_step) begin
                  hi_o  <= r_res;
                  lo_o  <= q_res;
                  state <= DONE;
               end
            end
            DONE: if (!ext_stall) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed and randomised divide transactions checked against a scoreboard of
// expected {hi, lo, div_zero, stall length} pushed at issue time.
module tb_div_seq_unit;

   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] F_DIV = 6'b011010;
   localparam logic [5:0] F_DIVU = 6'b011011;
   localparam logic [5:0] NOP_OP = 6'b111111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  op = NOP_OP;
   logic [5:0]  funct = '0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic        flush = 1'b0, ext_stall = 1'b0;
   logic        stall_div, hilo_we, div_zero;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          stalls;
   } exp_t;
   exp_t sb[$];

   logic [31:0] last_hi, last_lo;

   div_seq_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
      .flush(flush), .ext_stall(ext_stall), .stall_div(stall_div), .hilo_we(hilo_we),
      .hi_o(hi_o), .lo_o(lo_o), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   // Called just after a rising edge; returns just after a rising edge with EX cleared.
   task automatic do_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int est, input int ext_n);
      exp_t e;
      int   stalls = 0;
      int   holds = 0;
      bit   seen = 0;
      sb.push_back('{ehi, elo, edz, est});
      op = RTYPE; funct = f; rs_val = a; rt_val = b; ext_stall = (ext_n > 0);
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (stall_div) stalls++;
         else if (hilo_we) begin
            seen = 1;
            e = sb.pop_front();
            chk("stall_cycles", 64'(stalls), 64'(e.stalls));
            chk("lo", lo_o, e.lo);
            chk("hi", hi_o, e.hi);
            chk("div_zero", div_zero, e.dz);
            last_hi = e.hi;
            last_lo = e.lo;
         end else if (stalls > 0) begin
            holds++;
            chk("hold_lo", lo_o, sb[0].lo);
            chk("hold_hi", hi_o, sb[0].hi);
            if (holds == ext_n) begin
               @(posedge clk); #1 ext_stall = 1'b0;
            end
         end
      end
      chk("commit_seen", 64'(seen), 64'd1);
      chk("hold_cycles", 64'(holds), 64'(ext_n));
      if (!seen) void'(sb.pop_front());
      ext_stall = 1'b0;
      @(posedge clk); #1;
      op = NOP_OP; funct = '0;
   endtask

   initial begin
      logic [31:0] a, b;
      int          we_seen;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);
      chk("rst_we", hilo_we, 1'b0);
      chk("rst_stall", stall_div, 1'b0);
      chk("rst_dz", div_zero, 1'b0);
      @(posedge clk); #1;

      do_div(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0);
      do_div(F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33, 0);
      do_div(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 0);
      do_div(F_DIV, 32'd55, 32'd0, 32'd55, 32'hFFFFFFFF, 1'b1, 2, 0);
      do_div(F_DIV, 32'hFFFFFFB0, 32'd0, 32'hFFFFFFB0, 32'hFFFFFFFF, 1'b1, 2, 0);
      do_div(F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 3);
      @(negedge clk);
      chk("we_oneshot", hilo_we, 1'b0);
      chk("dz_idle", div_zero, 1'b0);

      // Flush in BUSY cycle 10.
      @(posedge clk); #1;
      op = RTYPE; funct = F_DIVU; rs_val = 32'hFFFFFFFF; rt_val = 32'd3;
      @(negedge clk);
      chk("flush_detect_stall", stall_div, 1'b1);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", stall_div, 1'b0);
      chk("flush_we", hilo_we, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0; op = NOP_OP; funct = '0;
      we_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hilo_we || stall_div) we_seen++;
      end
      chk("flush_quiet", 64'(we_seen), 64'd0);
      chk("flush_hi_kept", hi_o, last_hi);
      chk("flush_lo_kept", lo_o, last_lo);

      // Back-to-back issue.
      @(posedge clk); #1;
      do_div(F_DIVU, 32'd20, 32'd6, 32'd2, 32'd3, 1'b0, 33, 0);
      do_div(F_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 33, 0);

      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom_range(1, 5000);
         do_div(F_DIVU, a, b, a % b, a / b, 1'b0, 33, 0);
      end
      a = $urandom; b = 32'hFFFFFFFD;
      do_div(F_DIV, a, b, 32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b)), 1'b0, 33, 0);

      // Reset in BUSY cycle 5.
      op = RTYPE; funct = F_DIVU; rs_val = 32'hFFFFFFFF; rt_val = 32'd3;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1; op = NOP_OP; funct = '0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_hi", hi_o, 32'h0);
      chk("mid_rst_lo", lo_o, 32'h0);
      chk("mid_rst_stall", stall_div, 1'b0);
      chk("mid_rst_we", hilo_we, 1'b0);
      chk("mid_rst_dz", div_zero, 1'b0);
      we_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hilo_we || stall_div) we_seen++;
      end
      chk("mid_rst_quiet", 64'(we_seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
